// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tt_sweep_ctrl
// Description : Exhaustive truth-table sweeper and equivalence checker for a
//               single-output combinational (optionally pipelined) block.
//               Drives every minterm on o_x, captures i_y into o_tt after a
//               fixed latency of LAT cycles, and compares the captured table
//               against a golden table latched at start.
// Revision    : 1.0 - initial release
//
// Optional feature macro: TT_SWEEP_POPCOUNT_EN
//   When defined, the o_onset_cnt port and its counter are present.
//
// Parameters:
//   NIN  - number of inputs of the block under test (1..8)
//   LAT  - cycles from o_x change to valid i_y (0..7)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   i_start      in   sweep request, honoured only when idle
//   i_expected   in   golden truth table, bit k = f(k), latched on start
//   o_x          out  minterm driven to the block under test (registered)
//   i_y          in   block-under-test output
//   o_busy       out  sweep in progress
//   o_done       out  one-cycle completion pulse
//   o_tt         out  captured truth table, bit k = y for minterm k
//   o_mismatch   out  captured table differs from golden
//   o_first_err  out  lowest mismatching minterm index, 0 if none
//   o_onset_cnt  out  number of minterms with y=1 (popcount build only)
//==============================================================================
module tt_sweep_ctrl #(
   parameter int NIN = 6,
   parameter int LAT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic [2**NIN-1:0]   i_expected,
   output logic [NIN-1:0]      o_x,
   input  logic                i_y,
   output logic                o_busy,
   output logic                o_done,
   output logic [2**NIN-1:0]   o_tt,
   output logic                o_mismatch,
   output logic [NIN-1:0]      o_first_err
`ifdef TT_SWEEP_POPCOUNT_EN
   ,
   output logic [NIN:0]        o_onset_cnt
`endif
);

   localparam logic [2:0] c_LAT_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
   localparam logic [NIN:0] c_IDX_ONE = (NIN + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_busy;
   logic                w_done;

   // r_idx is one wider than o_x so the "all minterms driven" condition is
   // simply its MSB, exact even at NIN=8.
   logic [NIN:0]        r_idx;
   logic [NIN-1:0]      r_x;
   logic [2:0]          r_dcnt;
   logic [2**NIN-1:0]   r_exp;
   logic [2**NIN-1:0]   r_tt;
   logic                r_mis;
   logic [NIN-1:0]      r_ferr;

   // Capture stage: minterm index whose response is on i_y this cycle.
   logic                w_vld0;
   logic [NIN-1:0]      w_idx0;
   logic                w_cap_vld;
   logic [NIN-1:0]      w_cap_idx;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and status decode
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            w_busy = 1'b1;
            // MSB set means the last minterm is on o_x during this cycle.
            if (r_idx[NIN]) begin
               w_state_nxt = (LAT > 0) ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (r_dcnt == c_LAT_LAST) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Minterm generator, drain counter, capture and compare
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_x    <= '0;
         r_dcnt <= '0;
         r_exp  <= '0;
         r_tt   <= '0;
         r_mis  <= 1'b0;
         r_ferr <= '0;
      end else begin
         r_dcnt <= (r_state == ST_DRAIN) ? (r_dcnt + 3'd1) : 3'd0;
         if (w_accept) begin
            r_exp  <= i_expected;
            r_x    <= '0;
            r_idx  <= c_IDX_ONE;
            r_tt   <= '0;
            r_mis  <= 1'b0;
            r_ferr <= '0;
         end else begin
            if ((r_state == ST_SWEEP) && !r_idx[NIN]) begin
               r_x   <= r_idx[NIN-1:0];
               r_idx <= r_idx + c_IDX_ONE;
            end
            // o_x holds the last minterm through DRAIN/DONE, then returns to 0.
            if (r_state == ST_DONE) begin
               r_x <= '0;
            end
            if (w_cap_vld) begin
               r_tt[w_cap_idx] <= i_y;
               // Indices arrive in ascending order, so the first hit is the
               // lowest mismatching minterm.
               if ((i_y != r_exp[w_cap_idx]) && !r_mis) begin
                  r_mis  <= 1'b1;
                  r_ferr <= w_cap_idx;
               end
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Latency-matching pipeline of (valid, index) following o_x
   //---------------------------------------------------------------------------
   assign w_vld0 = (r_state == ST_SWEEP);
   assign w_idx0 = r_x;

   generate
      if (LAT == 0) begin : g_lat_zero
         assign w_cap_vld = w_vld0;
         assign w_cap_idx = w_idx0;
      end else begin : g_lat_pipe
         logic [LAT-1:0] r_pv;
         logic [NIN-1:0] r_pi [LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_pv <= '0;
               for (int i = 0; i < LAT; i++) begin
                  r_pi[i] <= '0;
               end
            end else begin
               r_pv[0] <= w_vld0;
               r_pi[0] <= w_idx0;
               for (int i = 1; i < LAT; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pi[i] <= r_pi[i-1];
               end
            end
         end

         assign w_cap_vld = r_pv[LAT-1];
         assign w_cap_idx = r_pi[LAT-1];
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Optional onset (y=1) counter
   //---------------------------------------------------------------------------
`ifdef TT_SWEEP_POPCOUNT_EN
   logic [NIN:0] r_onset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_onset <= '0;
      end else if (w_accept) begin
         r_onset <= '0;
      end else if (w_cap_vld && i_y) begin
         r_onset <= r_onset + c_IDX_ONE;
      end
   end

   assign o_onset_cnt = r_onset;
`else
   // Popcount build disabled: no onset counter.
`endif

   assign o_x         = r_x;
   assign o_busy      = w_busy;
   assign o_done      = w_done;
   assign o_tt        = r_tt;
   assign o_mismatch  = r_mis;
   assign o_first_err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_tt_sweep_ctrl
// Description : Scoreboard bench for tt_sweep_ctrl. Two instances (LAT=0 and
//               LAT=2, NIN=6) sweep a modelled block under test; expected
//               tables are computed from the block's function and queued at
//               start, and a monitor pops and compares on each done pulse.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_tt_sweep_ctrl;

   localparam int NIN = 6;
   localparam int NM  = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start0 = 1'b0;
   logic        start2 = 1'b0;
   logic [63:0] expected = '0;

   logic [5:0]  x0, x2, ferr0, ferr2, xd1, xd2;
   logic        y0, y2, busy0, busy2, done0, done2, mis0, mis2;
   logic [63:0] tt0, tt2;
`ifdef TT_SWEEP_POPCOUNT_EN
   logic [6:0]  on0, on2;
`endif

   always #5 clk = ~clk;

   // Block-under-test behaviour selected by mode.
   int mode = 0;
   bit tbl [64];

   function automatic logic model_y(int m, int k);
      int kk;
      kk = k;
      case (m)
         0:       return kk[0];
         1:       return kk[5];
         2:       return 1'b1;
         default: return tbl[kk & 63];
      endcase
   endfunction

   // LAT=0 instance sees a purely combinational block; LAT=2 instance sees
   // the same function behind a two-stage register pipeline.
   always @(posedge clk) begin
      xd1 <= x2;
      xd2 <= xd1;
   end
   assign y0 = model_y(mode, int'(x0));
   assign y2 = model_y(mode, int'(xd2));

   tt_sweep_ctrl #(.NIN(NIN), .LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_start(start0), .i_expected(expected),
      .o_x(x0), .i_y(y0), .o_busy(busy0), .o_done(done0), .o_tt(tt0),
      .o_mismatch(mis0), .o_first_err(ferr0)
`ifdef TT_SWEEP_POPCOUNT_EN
      , .o_onset_cnt(on0)
`endif
   );

   tt_sweep_ctrl #(.NIN(NIN), .LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_start(start2), .i_expected(expected),
      .o_x(x2), .i_y(y2), .o_busy(busy2), .o_done(done2), .o_tt(tt2),
      .o_mismatch(mis2), .o_first_err(ferr2)
`ifdef TT_SWEEP_POPCOUNT_EN
      , .o_onset_cnt(on2)
`endif
   );

   //---------------------------------------------------------------------------
   // Scoreboard
   //---------------------------------------------------------------------------
   typedef struct {
      logic [63:0] tt;
      logic        mis;
      logic [5:0]  ferr;
      logic [6:0]  onset;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   exp_t e_mon;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Expected result of sweeping the current mode against golden table gold;
   // done is due 2**NIN+lat edges after the accepting edge.
   function automatic exp_t build(logic [63:0] gold, int lat);
      exp_t        e;
      logic [63:0] diff;
      e.tt    = '0;
      e.onset = '0;
      for (int k = 0; k < NM; k++) begin
         e.tt[k] = model_y(mode, k);
         e.onset = e.onset + 7'(e.tt[k]);
      end
      diff   = e.tt ^ gold;
      e.mis  = |diff;
      e.ferr = '0;
      for (int k = NM - 1; k >= 0; k--) begin
         if (diff[k]) e.ferr = 6'(k);
      end
      e.cyc = cyc + 1 + NM + lat;
      return e;
   endfunction

   task automatic cmp_res(string tag, exp_t e, logic [63:0] tt, logic mis, logic [5:0] ferr);
      check({tag, "_tt"},        tt,           e.tt);
      check({tag, "_mismatch"},  64'(mis),     64'(e.mis));
      check({tag, "_first_err"}, 64'(ferr),    64'(e.ferr));
      check({tag, "_done_cyc"},  64'(cyc),     64'(e.cyc));
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut0_done: got unexpected done pulse, required none");
         end else begin
            e_mon = q0.pop_front();
            cmp_res("dut0", e_mon, tt0, mis0, ferr0);
`ifdef TT_SWEEP_POPCOUNT_EN
            check("dut0_onset", 64'(on0), 64'(e_mon.onset));
`endif
         end
      end
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dut2_done: got unexpected done pulse, required none");
         end else begin
            e_mon = q2.pop_front();
            cmp_res("dut2", e_mon, tt2, mis2, ferr2);
`ifdef TT_SWEEP_POPCOUNT_EN
            check("dut2_onset", 64'(on2), 64'(e_mon.onset));
`endif
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   // Per-cycle x/busy view j cycles after the accepting edge.
   task automatic chk_cycle(string tag, int j, int lat, logic [5:0] x, logic busy);
      check({tag, "_busy"}, 64'(busy), 64'(j < NM + lat));
      if (j < NM + lat)
         check({tag, "_x"}, 64'(x), 64'((j < NM) ? j : NM - 1));
      else if (j > NM + lat)
         check({tag, "_x_idle"}, 64'(x), 64'(0));
   endtask

   task automatic issue_start(logic [63:0] gold);
      @(negedge clk);
      expected = gold;
      start0   = 1'b1;
      start2   = 1'b1;
      q0.push_back(build(gold, 0));
      q2.push_back(build(gold, 2));
   endtask

   task automatic run_sweep(logic [63:0] gold, bit inject);
      issue_start(gold);
      for (int j = 0; j <= 70; j++) begin
         @(negedge clk);
         start0 = inject && ((j == 10) || (j == NM));
         start2 = inject && ((j == 10) || (j == NM + 2));
         if (j == 5) expected = {$urandom, $urandom};
         chk_cycle("dut0", j, 0, x0, busy0);
         chk_cycle("dut2", j, 2, x2, busy2);
      end
      start0 = 1'b0;
      start2 = 1'b0;
      check("dut0_pending", 64'(q0.size()), 64'(0));
      check("dut2_pending", 64'(q2.size()), 64'(0));
   endtask

   task automatic chk_reset_state();
      check("rst_x0",     64'(x0),    64'(0));
      check("rst_busy0",  64'(busy0), 64'(0));
      check("rst_done0",  64'(done0), 64'(0));
      check("rst_tt0",    tt0,        64'(0));
      check("rst_mis0",   64'(mis0),  64'(0));
      check("rst_ferr0",  64'(ferr0), 64'(0));
      check("rst_x2",     64'(x2),    64'(0));
      check("rst_busy2",  64'(busy2), 64'(0));
      check("rst_done2",  64'(done2), 64'(0));
      check("rst_tt2",    tt2,        64'(0));
      check("rst_mis2",   64'(mis2),  64'(0));
      check("rst_ferr2",  64'(ferr2), 64'(0));
`ifdef TT_SWEEP_POPCOUNT_EN
      check("rst_onset0", 64'(on0),   64'(0));
      check("rst_onset2", 64'(on2),   64'(0));
`endif
   endtask

   task automatic reset_mid_sweep(logic [63:0] gold);
      issue_start(gold);
      for (int j = 0; j <= 20; j++) begin
         @(negedge clk);
         start0 = 1'b0;
         start2 = 1'b0;
      end
      check("pre_rst_x0", 64'(x0), 64'(20));
      check("pre_rst_x2", 64'(x2), 64'(20));
      rst_n = 1'b0;
      #1;
      chk_reset_state();
      q0.delete();
      q2.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [63:0] gold;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_state();
      rst_n = 1'b1;

      mode = 0;
      run_sweep(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      run_sweep(64'hAAAA_AAAA_AAAA_AAAA ^ (64'h1 << 13) ^ (64'h1 << 40), 1'b0);

      mode = 1;
      run_sweep(64'hFFFF_FFFF_0000_0000, 1'b1);

      mode = 2;
      run_sweep({$urandom, $urandom}, 1'b1);

      mode = 0;
      reset_mid_sweep(64'hAAAA_AAAA_AAAA_AAAA);
      run_sweep(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);

      mode = 3;
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < NM; k++) tbl[k] = bit'($urandom_range(0, 1));
         for (int k = 0; k < NM; k++) gold[k] = tbl[k];
         if (r != 0) begin
            for (int f = 0; f < r; f++) gold[$urandom_range(0, NM - 1)] ^= 1'b1;
         end
         run_sweep(gold, bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively drives every input minterm of a small combinational logic block under test (single output, up to 8 inputs), captures its response into a truth-table register and compares it against a golden truth table. It sits beside the optimized netlists of the benchmark set as the on-chip equivalence checker. It tolerates a pipelined block under test via a fixed capture latency.

## Interface
- NIN, 6, number of inputs of the block under test, legal 1..8
- LAT, 0, cycles from `x` change to valid `y`, legal 0..7
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sweep request, sampled in IDLE only
- expected  in  2**NIN  golden truth table, bit k = f(k); latched on accepted start
- x  out  NIN  minterm driven to block under test (registered)
- y  in  1  block-under-test output
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- tt  out  2**NIN  captured truth table, bit k = y for minterm k
- mismatch  out  1  captured table differs from golden
- first_err  out  NIN  lowest minterm index that mismatched; 0 if none
- onset_cnt  out  NIN+1  number of minterms with y=1 (only with TT_SWEEP_POPCOUNT_EN)

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: x=0, busy=0. start=1 at edge -> latch expected, clear tt/mismatch/first_err/onset_cnt, idx=0, go SWEEP.
- SWEEP: x=idx; idx increments each cycle; after driving idx=2**NIN-1 go DRAIN (LAT>0) or DONE (LAT=0). idx width NIN+1 so terminal detection is exact at NIN=8.
- DRAIN: x holds last minterm; LAT cycles, then DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE. start in DONE ignored.
- Capture: a LAT-deep pipeline of (valid, index) follows x; when valid emerges, tt[index]<=y; if y!=expected_latched[index] and mismatch==0, set mismatch, first_err<=index (sticky, records lowest since indices ascend).
- start while busy ignored; expected changes after acceptance have no effect.
- tt, mismatch, first_err, onset_cnt hold their values after DONE until the next accepted start.
- Reset (any time, including mid-sweep): state IDLE; x, busy, done, tt, mismatch, first_err, onset_cnt, capture pipeline all 0.

## Timing
- Start accepted at edge E0; x=k visible after edge E0+k (k=0..2**NIN-1).
- y for minterm k sampled at edge E0+k+LAT+1.
- busy=1 from after E0 through the last SWEEP/DRAIN cycle; done=1 in the cycle after edge E0+2**NIN+LAT; start-to-done latency 2**NIN+LAT+1 cycles.
- mismatch/first_err valid no later than done; tt final when done=1.
- Next start accepted earliest the cycle after done (IDLE).

## Configuration
- TT_SWEEP_POPCOUNT_EN defined: onset_cnt port present; increments by 1 on each capture with y=1; cleared on accepted start; holds after done; range 0..2**NIN.
- Undefined: onset_cnt port and counter absent; all other behaviour identical.

## Test plan
- NIN=6, LAT=0, model y=x[0], expected=64'hAAAA_AAAA_AAAA_AAAA, start -> done exactly 65 cycles after start edge, tt=64'hAAAA_AAAA_AAAA_AAAA, mismatch=0, first_err=0.
- Same but expected bits 13 and 40 flipped -> mismatch=1, first_err=13, tt unchanged.
- NIN=6, LAT=2, model y=x[5] delayed 2 cycles, expected=64'hFFFF_FFFF_0000_0000 -> done 67 cycles after start, mismatch=0; x holds 63 during DRAIN.
- Assert rst_n low while x=20 mid-sweep -> x=0, busy=0, tt=0, mismatch=0 immediately; new start yields full correct sweep.
- Pulse start at x=10 during busy and in DONE cycle -> ignored, single done pulse, results unaffected.
- With TT_SWEEP_POPCOUNT_EN: y=x[0] -> onset_cnt=32; y=1 constant -> onset_cnt=64 (7-bit), tt all ones.
